// File: rtl/regs.sv
// pMIPS general-purpose register file: 32 x n bits, one write port,
// two combinational read ports, register 0 hard-wired to zero.
module regs #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         w,
    input  logic [n-1:0] Wdata,
    input  logic [4:0]   rs,
    input  logic [4:0]   rd,
    output logic [n-1:0] rs_data,
    output logic [n-1:0] rd_data
);

    logic [n-1:0] mem [32];

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (w && (rd != 5'd0)) begin
            mem[rd] <= Wdata;
        end
    end

    // Address 0 is masked on read so it reads zero even before first reset.
    always_comb begin
        rs_data = '0;
        rd_data = '0;
        if (rs != 5'd0) begin
            rs_data = mem[rs];
        end
        if (rd != 5'd0) begin
            rd_data = mem[rd];
        end
    end

endmodule

// File: tb/tb_regs.sv
// Directed self-checking bench for the regs register file.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_regs;

    logic       clk;
    logic       n_reset;
    logic       w;
    logic [7:0] Wdata;
    logic [4:0] rs;
    logic [4:0] rd;
    logic [7:0] rs_data;
    logic [7:0] rd_data;

    int checks;
    int failures;

    regs #(.n(8)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .w       (w),
        .Wdata   (Wdata),
        .rs      (rs),
        .rd      (rd),
        .rs_data (rs_data),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_reset  = 1'b0;
        w        = 1'b0;
        Wdata    = 8'h00;
        rs       = 5'd0;
        rd       = 5'd0;

        // reset then sweep every address on both ports
        tick();
        n_reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i);
            rd = 5'(31 - i);
            #2;
            check("reset_rs", rs_data, 8'h00);
            check("reset_rd", rd_data, 8'h00);
        end

        // basic write/read
        w = 1'b1; rd = 5'd1; Wdata = 8'd3;
        tick();
        rd = 5'd6; Wdata = 8'd11; rs = 5'd1;
        tick();
        w = 1'b0;
        #2;
        check("basic_rs1", rs_data, 8'd3);
        check("basic_rd6", rd_data, 8'd11);

        // zero register
        w = 1'b1; rd = 5'd0; Wdata = 8'hFF;
        tick();
        w = 1'b0;
        #2;
        check("zero_rd", rd_data, 8'h00);
        rs = 5'd0;
        #2;
        check("zero_rs", rs_data, 8'h00);
        rs = 5'd1;
        #2;
        check("zero_keep_r1", rs_data, 8'd3);

        // write enable low
        w = 1'b0; rd = 5'd6; Wdata = 8'h55;
        tick();
        #2;
        check("we_low_r6", rd_data, 8'd11);

        // no bypass, one-cycle latency
        w = 1'b1; rd = 5'd5; Wdata = 8'd7;
        tick();
        rs = 5'd5; rd = 5'd5; Wdata = 8'd9;
        #2;
        check("nobyp_pre_rs", rs_data, 8'd7);
        check("nobyp_pre_rd", rd_data, 8'd7);
        tick();
        w = 1'b0;
        #2;
        check("nobyp_post_rs", rs_data, 8'd9);
        check("nobyp_post_rd", rd_data, 8'd9);

        // high address, then reset priority over write
        w = 1'b1; rd = 5'd31; Wdata = 8'hA5;
        tick();
        w = 1'b0; rs = 5'd31;
        #2;
        check("r31_write", rs_data, 8'hA5);
        n_reset = 1'b0; w = 1'b1; rd = 5'd31; Wdata = 8'h3C;
        #2;
        check("r31_pre_rst", rs_data, 8'hA5);
        tick();
        n_reset = 1'b1; w = 1'b0;
        #2;
        check("rst_pri_rs", rs_data, 8'h00);
        check("rst_pri_rd", rd_data, 8'h00);
        rs = 5'd6;
        #2;
        check("rst_clr_r6", rs_data, 8'h00);
        rs = 5'd5;
        #2;
        check("rst_clr_r5", rs_data, 8'h00);

        // writes resume after reset release
        w = 1'b1; rd = 5'd2; Wdata = 8'h80;
        tick();
        w = 1'b0; rs = 5'd2; rd = 5'd1;
        #2;
        check("resume_r2", rs_data, 8'h80);
        check("resume_r1", rd_data, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
